// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
//   fwd_sel_t   : operand forwarding mux select (none / from W / from M)
//   mdu_state_t : MDU handshake FSM states
//   reg_match   : register-index compare honouring a hardwired-zero x0
package hazard_pkg;

  // Widest register index the match helper accepts (NREG up to 256).
  localparam int unsigned REG_IDX_W = 8;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

  // True when the indices are equal, except that index 0 never matches
  // when register 0 is hardwired.
  function automatic logic reg_match(input logic [REG_IDX_W-1:0] a,
                                     input logic [REG_IDX_W-1:0] b,
                                     input logic                 zero_hw);
    return (a == b) && !(zero_hw && (a == '0));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc_i      : count up by one (holds at all-ones)
//   clr_i      : synchronous clear, wins over inc_i
//   cnt_o      : current count
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear first, otherwise increment until all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: operand forwarding,
// load-use stalls, branch flushes, data-memory freeze and a blocking MDU
// handshake with timeout, plus a saturating stall-cycle counter.
//   Inputs : stage register indices, RegWrite/load/branch flags, MDU op/done,
//            data-memory request/ready, stall counter clear
//   Outputs: ForwardAE/BE, per-stage Stall*/Flush*, MduGoE (start pulse),
//            MduTimeout (sticky), StallCycles
// Forward/stall/flush/MduGoE are combinational from inputs and FSM state.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned NREG           = 32,
  parameter bit          ZERO_HARDWIRED = 1'b1,
  parameter int unsigned MDU_TIMEOUT    = 64,
  parameter int unsigned CW             = 32,
  localparam int unsigned AW            = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] Rs1D,
  input  logic [AW-1:0] Rs2D,
  input  logic [AW-1:0] Rs1E,
  input  logic [AW-1:0] Rs2E,
  input  logic [AW-1:0] RdE,
  input  logic [AW-1:0] RdM,
  input  logic [AW-1:0] RdW,
  input  logic          RegWriteM,
  input  logic          RegWriteW,
  input  logic          ResultSrcEb0,
  input  logic          PCSrcE,
  input  logic          MduOpE,
  input  logic          MduDoneE,
  input  logic          MemReqM,
  input  logic          MemReadyM,
  input  logic          CntClr,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
  output logic          StallF,
  output logic          StallD,
  output logic          StallE,
  output logic          StallM,
  output logic          FlushD,
  output logic          FlushE,
  output logic          FlushM,
  output logic          FlushW,
  output logic          MduGoE,
  output logic          MduTimeout,
  output logic [CW-1:0] StallCycles
);

  localparam int unsigned BW = $clog2(MDU_TIMEOUT + 1);

  mdu_state_t    state_q, state_d;
  logic          hold_q, hold_d;       // MDU result ready, E still frozen by memory
  logic          timeout_q, timeout_d;
  logic [BW-1:0] busy_cnt;
  logic          memstall, busy, to_hit, mdu_end, launch, load_use;
  fwd_sel_t      fwd_a, fwd_b;

  function automatic logic rmatch(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return reg_match(REG_IDX_W'(a), REG_IDX_W'(b), ZERO_HARDWIRED);
  endfunction

  assign memstall = MemReqM & ~MemReadyM;
  assign busy     = (state_q == BUSY);
  // Last allowed busy cycle: the counter reaches MDU_TIMEOUT on this edge.
  assign to_hit   = busy & (busy_cnt == BW'(MDU_TIMEOUT - 1));
  assign mdu_end  = busy & (MduDoneE | to_hit);
  // hold_q blocks a relaunch of an op whose result already came back.
  assign launch   = ~busy & MduOpE & ~memstall & ~hold_q;
  assign load_use = ResultSrcEb0 & (rmatch(RdE, Rs1D) | rmatch(RdE, Rs2D));

  // Operand forwarding, M stage has priority over W.
  always_comb begin
    fwd_a = FWD_NONE;
    fwd_b = FWD_NONE;
    if (RegWriteM && rmatch(RdM, Rs1E))      fwd_a = FWD_M;
    else if (RegWriteW && rmatch(RdW, Rs1E)) fwd_a = FWD_W;
    if (RegWriteM && rmatch(RdM, Rs2E))      fwd_b = FWD_M;
    else if (RegWriteW && rmatch(RdW, Rs2E)) fwd_b = FWD_W;
  end

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;

  // MDU FSM next state plus stall/flush priority:
  // memory freeze > MDU wait > branch > load-use.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    timeout_d = timeout_q;
    MduGoE    = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    FlushW    = 1'b0;

    if (mdu_end) begin
      state_d = IDLE;
      hold_d  = memstall;
      if (!MduDoneE) timeout_d = 1'b1;
    end else if (launch) begin
      state_d = BUSY;
      MduGoE  = 1'b1;
    end else if (!memstall) begin
      hold_d = 1'b0;
    end

    if (memstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (launch || (busy && !mdu_end)) begin
      // The op sits in E from its start pulse until its done cycle.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (busy) begin
      // Done/timeout cycle: E released, D-stage hazards still ignored.
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (load_use) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      hold_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign MduTimeout = timeout_q;

  sat_counter #(.W(CW)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc_i (StallF),
    .clr_i (CntClr),
    .cnt_o (StallCycles)
  );

  sat_counter #(.W(BW)) u_busy_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc_i (busy),
    .clr_i (~busy),
    .cnt_o (busy_cnt)
  );

endmodule
